mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_rr_picker.sv | 32 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared defaults and FSM state encoding for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned ADDR_W_DEF  = 11;
    localparam int unsigned DATA_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or above ptr, wrapping to 0.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned PTR_W   = ptr_width(NUM_REQ_DEF)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   index
);

    // Walk the requesters starting at ptr and keep the first one found.
    always_comb begin
        int unsigned cand;
        cand  = 0;
        valid = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid && req[PTR_W'(cand)]) begin
                valid = 1'b1;
                index = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_REQ cores onto one memory read/write port, one access at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] adrs,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_r_en,
    output logic                      mem_w_en,
    output logic [ADDR_W-1:0]         mem_r_adrs,
    output logic [ADDR_W-1:0]         mem_w_adrs,
    output logic [DATA_W-1:0]         mem_data_in,
    input  logic [DATA_W-1:0]         mem_data_out,
    input  logic                      mem_r_valid,
    output logic                      busy
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);

    arb_state_e           state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_d;
    logic [PTR_W-1:0]     idx_q;
    logic                 we_q;
    logic [ADDR_W-1:0]    adrs_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 r_en_q;
    logic                 w_en_q;

    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_we;
    logic [ADDR_W-1:0]    pick_adrs;
    logic [DATA_W-1:0]    pick_wdata;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // Select the winner's request fields and the pointer that follows it.
    always_comb begin
        pick_we    = we[pick_idx];
        pick_adrs  = adrs[32'(pick_idx) * ADDR_W +: ADDR_W];
        pick_wdata = wdata[32'(pick_idx) * DATA_W +: DATA_W];
        if (32'(pick_idx) == NUM_REQ - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = pick_idx + PTR_W'(1);
        end
    end

    // Arbitration FSM with registered grant and memory enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            adrs_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            r_en_q  <= 1'b0;
            w_en_q  <= 1'b0;
        end else begin
            gnt_q  <= '0;
            r_en_q <= 1'b0;
            w_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        idx_q   <= pick_idx;
                        we_q    <= pick_we;
                        adrs_q  <= pick_adrs;
                        wdata_q <= pick_wdata;
                        ptr_q   <= ptr_d;
                        gnt_q   <= NUM_REQ'(1) << pick_idx;
                        w_en_q  <= pick_we;
                        r_en_q  <= ~pick_we;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= we_q ? IDLE : WAIT;
                end
                WAIT: begin
                    if (mem_r_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read data is forwarded in the same cycle the memory flags it valid.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (state_q == WAIT && mem_r_valid) begin
            rvalid = NUM_REQ'(1) << idx_q;
            rdata  = mem_data_out;
        end
    end

    assign gnt         = gnt_q;
    assign mem_r_en    = r_en_q;
    assign mem_w_en    = w_en_q;
    assign mem_r_adrs  = adrs_q;
    assign mem_w_adrs  = adrs_q;
    assign mem_data_in = wdata_q;
    assign busy        = (state_q != IDLE);

endmodule
